// File: rtl/tlp_snoop_arb.sv
// tlp_snoop_arb
//   Packet-atomic round-robin arbiter that drains the RX-snoop and TX-snoop
//   first-word-fall-through FIFOs into a single 64-bit stream for the NetTLP
//   encapsulator. Each packet carries a direction tag plus the TLP length/tag
//   captured from its first beat. Packets that reach MAX_BEATS without tlast
//   are cut short (last beat forced) and their remainder is drained silently.
//
// Ports
//   pcie_clk, pcie_rst        clock, asynchronous active-high reset
//   snoop_en[1:0]             bit0 RX enable, bit1 TX enable (sampled at grant)
//   rx_* / tx_*               FIFO head (empty, data, keep, last, len, tag), pop
//   m_t*                      output stream with dir/len/tag sideband
//   busy                      arbiter is not idle
//   rx_pkt_cnt, tx_pkt_cnt    saturating forwarded-packet counters
//   trunc_cnt                 saturating truncated-packet counter
module tlp_snoop_arb #(
    parameter int unsigned MAX_BEATS = 514,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             pcie_clk,
    input  logic             pcie_rst,
    input  logic [1:0]       snoop_en,

    input  logic             rx_empty,
    output logic             rx_rd_en,
    input  logic [63:0]      rx_tdata,
    input  logic [7:0]       rx_tkeep,
    input  logic             rx_tlast,
    input  logic [10:0]      rx_tlp_len,
    input  logic [7:0]       rx_tlp_tag,

    input  logic             tx_empty,
    output logic             tx_rd_en,
    input  logic [63:0]      tx_tdata,
    input  logic [7:0]       tx_tkeep,
    input  logic             tx_tlast,
    input  logic [10:0]      tx_tlp_len,
    input  logic [7:0]       tx_tlp_tag,

    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [63:0]      m_tdata,
    output logic [7:0]       m_tkeep,
    output logic             m_tlast,
    output logic             m_tdir,
    output logic [10:0]      m_tlp_len,
    output logic [7:0]       m_tlp_tag,

    output logic             busy,
    output logic [CNT_W-1:0] rx_pkt_cnt,
    output logic [CNT_W-1:0] tx_pkt_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);

    localparam int unsigned BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {StIdle, StXfer, StDrain} state_t;

    state_t           state_q, state_d;
    logic             dir_q;          // 0 = RX, 1 = TX
    logic             last_grant_q;
    logic [10:0]      len_q;
    logic [7:0]       tag_q;
    logic [BW-1:0]    beat_q;

    logic             m_tvalid_q, m_tlast_q, m_tdir_q;
    logic [63:0]      m_tdata_q;
    logic [7:0]       m_tkeep_q;
    logic [10:0]      m_tlp_len_q;
    logic [7:0]       m_tlp_tag_q;
    logic [CNT_W-1:0] rx_cnt_q, tx_cnt_q, trunc_cnt_q;

    // Selected (granted) FIFO head
    logic             sel_empty, sel_tlast;
    logic [63:0]      sel_tdata;
    logic [7:0]       sel_tkeep;

    logic             adv, pop, rx_elig, tx_elig, grant, grant_dir;
    logic             beat_limit, xfer_pop, pkt_done, pkt_trunc;

    assign sel_empty = dir_q ? tx_empty : rx_empty;
    assign sel_tlast = dir_q ? tx_tlast : rx_tlast;
    assign sel_tdata = dir_q ? tx_tdata : rx_tdata;
    assign sel_tkeep = dir_q ? tx_tkeep : rx_tkeep;

    assign adv        = !m_tvalid_q || m_tready;
    assign rx_elig    = !rx_empty && snoop_en[0];
    assign tx_elig    = !tx_empty && snoop_en[1];
    // The beat being popped now is number beat_q + 1.
    assign beat_limit = (beat_q == BW'(MAX_BEATS - 1));

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        grant     = 1'b0;
        grant_dir = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (rx_elig || tx_elig) begin
                    grant = 1'b1;
                    if (rx_elig && tx_elig) grant_dir = !last_grant_q;
                    else                    grant_dir = tx_elig;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                pop = !sel_empty && adv;
                if (pop) begin
                    if (sel_tlast)       state_d = StIdle;
                    else if (beat_limit) state_d = StDrain;
                end
            end
            StDrain: begin
                // Discard remainder without waiting on the output stage.
                pop = !sel_empty;
                if (pop && sel_tlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign xfer_pop  = (state_q == StXfer) && pop;
    assign pkt_done  = xfer_pop && sel_tlast;
    assign pkt_trunc = xfer_pop && !sel_tlast && beat_limit;

    assign rx_rd_en = pop && !dir_q;
    assign tx_rd_en = pop && dir_q;

    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            state_q      <= StIdle;
            dir_q        <= 1'b0;
            last_grant_q <= 1'b1;     // TX, so RX wins the first tie
            len_q        <= '0;
            tag_q        <= '0;
            beat_q       <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                dir_q        <= grant_dir;
                last_grant_q <= grant_dir;
                len_q        <= grant_dir ? tx_tlp_len : rx_tlp_len;
                tag_q        <= grant_dir ? tx_tlp_tag : rx_tlp_tag;
                beat_q       <= '0;
            end else if (xfer_pop) begin
                beat_q <= beat_q + BW'(1);
            end
        end
    end

    // Single-register output stage.
    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            m_tvalid_q  <= 1'b0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tlast_q   <= 1'b0;
            m_tdir_q    <= 1'b0;
            m_tlp_len_q <= '0;
            m_tlp_tag_q <= '0;
        end else if (xfer_pop) begin
            m_tvalid_q  <= 1'b1;
            m_tdata_q   <= sel_tdata;
            m_tkeep_q   <= sel_tkeep;
            m_tlast_q   <= sel_tlast || beat_limit;
            m_tdir_q    <= dir_q;
            m_tlp_len_q <= len_q;
            m_tlp_tag_q <= tag_q;
        end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    // Saturating statistics.
    always_ff @(posedge pcie_clk or posedge pcie_rst) begin
        if (pcie_rst) begin
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            trunc_cnt_q <= '0;
        end else begin
            if (pkt_done && !dir_q && rx_cnt_q != '1) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            if (pkt_done && dir_q && tx_cnt_q != '1)  tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            if (pkt_trunc && trunc_cnt_q != '1)       trunc_cnt_q <= trunc_cnt_q + CNT_W'(1);
        end
    end

    assign m_tvalid   = m_tvalid_q;
    assign m_tdata    = m_tdata_q;
    assign m_tkeep    = m_tkeep_q;
    assign m_tlast    = m_tlast_q;
    assign m_tdir     = m_tdir_q;
    assign m_tlp_len  = m_tlp_len_q;
    assign m_tlp_tag  = m_tlp_tag_q;
    assign busy       = (state_q != StIdle);
    assign rx_pkt_cnt = rx_cnt_q;
    assign tx_pkt_cnt = tx_cnt_q;
    assign trunc_cnt  = trunc_cnt_q;

endmodule

// File: tb/tb_tlp_snoop_arb.sv
// tb_tlp_snoop_arb
//   Directed bench for tlp_snoop_arb with MAX_BEATS = 4. Both snoop FIFOs are
//   modelled as first-word-fall-through queues; accepted output beats are
//   collected and compared against bench-built expected packets.
module tb_tlp_snoop_arb;

    localparam int unsigned MAXB = 4;
    localparam int unsigned CW   = 32;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst = 1'b1;
    logic [1:0]    snoop_en;
    logic          rx_empty, rx_rd_en, rx_tlast;
    logic [63:0]   rx_tdata;
    logic [7:0]    rx_tkeep, rx_tlp_tag;
    logic [10:0]   rx_tlp_len;
    logic          tx_empty, tx_rd_en, tx_tlast;
    logic [63:0]   tx_tdata;
    logic [7:0]    tx_tkeep, tx_tlp_tag;
    logic [10:0]   tx_tlp_len;
    logic          m_tvalid, m_tready, m_tlast, m_tdir, busy;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep, m_tlp_tag;
    logic [10:0]   m_tlp_len;
    logic [CW-1:0] rx_pkt_cnt, tx_pkt_cnt, trunc_cnt;

    tlp_snoop_arb #(.MAX_BEATS(MAXB), .CNT_W(CW)) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst), .snoop_en(snoop_en),
        .rx_empty(rx_empty), .rx_rd_en(rx_rd_en), .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep),
        .rx_tlast(rx_tlast), .rx_tlp_len(rx_tlp_len), .rx_tlp_tag(rx_tlp_tag),
        .tx_empty(tx_empty), .tx_rd_en(tx_rd_en), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep),
        .tx_tlast(tx_tlast), .tx_tlp_len(tx_tlp_len), .tx_tlp_tag(tx_tlp_tag),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tdir(m_tdir), .m_tlp_len(m_tlp_len), .m_tlp_tag(m_tlp_tag),
        .busy(busy), .rx_pkt_cnt(rx_pkt_cnt), .tx_pkt_cnt(tx_pkt_cnt), .trunc_cnt(trunc_cnt)
    );

    always #5 pcie_clk = ~pcie_clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [10:0] len;
        logic [7:0]  tag;
    } ent_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        dir;
        logic [10:0] len;
        logic [7:0]  tag;
    } beat_t;

    typedef struct {
        logic        dir;
        int          nb;
        logic [10:0] len;
        logic [7:0]  tag;
        int          exp_nb;
        logic        exp_trunc;
    } vec_t;

    ent_t  rx_q[$], tx_q[$];
    beat_t out_q[$], exp_q[$];
    vec_t  vecs[5];

    int total = 0;
    int bad   = 0;
    int viol_empty = 0, viol_stall_pop = 0, viol_hold = 0, viol_rx_dis = 0;
    int exp_rx = 0, exp_tx = 0, exp_tr = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_d = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input logic dir, input logic [7:0] tag, input int i);
        return {8'hA5, 7'd0, dir, tag, 8'h00, 32'(i)};
    endfunction

    task automatic drive_heads();
        rx_empty   = (rx_q.size() == 0);
        tx_empty   = (tx_q.size() == 0);
        rx_tdata   = rx_empty ? 64'hDEAD : rx_q[0].d;
        rx_tkeep   = rx_empty ? 8'h00 : rx_q[0].k;
        rx_tlast   = rx_empty ? 1'b0 : rx_q[0].l;
        rx_tlp_len = rx_empty ? 11'h0 : rx_q[0].len;
        rx_tlp_tag = rx_empty ? 8'h00 : rx_q[0].tag;
        tx_tdata   = tx_empty ? 64'hBEEF : tx_q[0].d;
        tx_tkeep   = tx_empty ? 8'h00 : tx_q[0].k;
        tx_tlast   = tx_empty ? 1'b0 : tx_q[0].l;
        tx_tlp_len = tx_empty ? 11'h0 : tx_q[0].len;
        tx_tlp_tag = tx_empty ? 8'h00 : tx_q[0].tag;
    endtask

    // Sideband is only valid on the first beat; later beats carry junk.
    task automatic push_pkt(input logic dir, input int nb, input logic [10:0] len,
                            input logic [7:0] tag);
        ent_t e;
        for (int i = 0; i < nb; i++) begin
            e.d   = mkdata(dir, tag, i);
            e.k   = (i == nb - 1) ? 8'h0F : 8'hFF;
            e.l   = (i == nb - 1);
            e.len = (i == 0) ? len : 11'h7FF;
            e.tag = (i == 0) ? tag : 8'hEE;
            if (dir) tx_q.push_back(e);
            else     rx_q.push_back(e);
        end
        drive_heads();
    endtask

    task automatic exp_pkt(input logic dir, input int nb_out, input int nb_in,
                           input logic [10:0] len, input logic [7:0] tag);
        beat_t b;
        for (int i = 0; i < nb_out; i++) begin
            b.d   = mkdata(dir, tag, i);
            b.k   = (i == nb_in - 1) ? 8'h0F : 8'hFF;
            b.l   = (i == nb_out - 1);
            b.dir = dir;
            b.len = len;
            b.tag = tag;
            exp_q.push_back(b);
        end
    endtask

    // One clock: sample just before the edge, pop FIFOs that the DUT popped.
    task automatic tick();
        logic  pre_rx, pre_tx;
        beat_t b;
        #1;
        pre_rx = rx_rd_en;
        pre_tx = tx_rd_en;
        if (pre_rx && rx_q.size() == 0) viol_empty++;
        if (pre_tx && tx_q.size() == 0) viol_empty++;
        if (pre_rx && m_tvalid && !m_tready) viol_stall_pop++;
        if (pre_rx && !snoop_en[0]) viol_rx_dis++;
        if (prev_stall && (!m_tvalid || m_tdata !== prev_d)) viol_hold++;
        prev_stall = m_tvalid && !m_tready;
        prev_d     = m_tdata;
        if (m_tvalid && m_tready) begin
            b.d = m_tdata; b.k = m_tkeep; b.l = m_tlast; b.dir = m_tdir;
            b.len = m_tlp_len; b.tag = m_tlp_tag;
            out_q.push_back(b);
        end
        @(posedge pcie_clk);
        #1;
        if (pre_rx && rx_q.size() != 0) rx_q.delete(0);
        if (pre_tx && tx_q.size() != 0) tx_q.delete(0);
        drive_heads();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int   n = 0;
        logic done;
        done = 1'b0;
        while (!done && n < budget) begin
            tick();
            n++;
            done = rx_q.size() == 0 && tx_q.size() == 0 && !busy && !m_tvalid;
        end
        chk({nm, "_idle"}, done, 1'b1);
    endtask

    task automatic compare_out(input string nm);
        chk({nm, "_nbeats"}, out_q.size(), exp_q.size());
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_cnts(input string nm);
        chk({nm, "_rxcnt"}, rx_pkt_cnt, exp_rx);
        chk({nm, "_txcnt"}, tx_pkt_cnt, exp_tx);
        chk({nm, "_trcnt"}, trunc_cnt, exp_tr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        // dir, beats in, len, tag, beats out, truncated
        vecs[0] = '{1'b0, 3, 11'd16,  8'h05, 3, 1'b0};
        vecs[1] = '{1'b0, 4, 11'd24,  8'h06, 4, 1'b0};  // exactly MAXB with tlast
        vecs[2] = '{1'b1, 2, 11'd32,  8'h11, 2, 1'b0};
        vecs[3] = '{1'b1, 7, 11'd100, 8'h12, 4, 1'b1};  // runaway, cut at MAXB
        vecs[4] = '{1'b1, 1, 11'd4,   8'h13, 1, 1'b0};  // intact after truncation

        snoop_en = 2'b11;
        m_tready = 1'b1;
        drive_heads();
        repeat (3) @(posedge pcie_clk);
        #1;
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, 64'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", {rx_rd_en, tx_rd_en}, 2'b00);
        chk_cnts("rst");
        pcie_rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            push_pkt(vecs[v].dir, vecs[v].nb, vecs[v].len, vecs[v].tag);
            exp_pkt(vecs[v].dir, vecs[v].exp_nb, vecs[v].nb, vecs[v].len, vecs[v].tag);
            wait_idle($sformatf("vec%0d", v), 60);
            compare_out($sformatf("vec%0d", v));
            if (vecs[v].exp_trunc) exp_tr++;
            else if (vecs[v].dir)  exp_tx++;
            else                   exp_rx++;
            chk_cnts($sformatf("vec%0d", v));
        end

        // Two packets per FIFO, last grant was TX: RX, TX, RX, TX.
        push_pkt(1'b0, 2, 11'd8, 8'h21);
        push_pkt(1'b0, 2, 11'd8, 8'h22);
        push_pkt(1'b1, 2, 11'd8, 8'h31);
        push_pkt(1'b1, 3, 11'd12, 8'h32);
        exp_pkt(1'b0, 2, 2, 11'd8, 8'h21);
        exp_pkt(1'b1, 2, 2, 11'd8, 8'h31);
        exp_pkt(1'b0, 2, 2, 11'd8, 8'h22);
        exp_pkt(1'b1, 3, 3, 11'd12, 8'h32);
        wait_idle("alt", 80);
        compare_out("alt");
        exp_rx += 2;
        exp_tx += 2;
        chk_cnts("alt");

        // Backpressure toggling during a 4-beat packet.
        viol_stall_pop = 0;
        viol_hold = 0;
        push_pkt(1'b0, 4, 11'd64, 8'h41);
        exp_pkt(1'b0, 4, 4, 11'd64, 8'h41);
        begin
            int   n = 0;
            logic done;
            done = 1'b0;
            while (!done && n < 60) begin
                m_tready = (n % 2 == 0);
                tick();
                n++;
                done = rx_q.size() == 0 && !busy && !m_tvalid;
            end
            chk("bp_idle", done, 1'b1);
        end
        m_tready = 1'b1;
        compare_out("bp");
        chk("bp_pop_while_stalled", viol_stall_pop, 0);
        chk("bp_hold", viol_hold, 0);
        exp_rx++;
        chk_cnts("bp");

        // RX disabled: only TX drains, RX stays queued.
        snoop_en = 2'b10;
        viol_rx_dis = 0;
        push_pkt(1'b0, 1, 11'd4, 8'h51);
        push_pkt(1'b1, 2, 11'd8, 8'h61);
        exp_pkt(1'b1, 2, 2, 11'd8, 8'h61);
        repeat (20) tick();
        chk("dis_rx_left", rx_q.size(), 1);
        chk("dis_rx_rd", viol_rx_dis, 0);
        compare_out("dis");
        exp_tx++;
        chk_cnts("dis");
        snoop_en = 2'b11;
        exp_pkt(1'b0, 1, 1, 11'd4, 8'h51);
        wait_idle("reen", 30);
        compare_out("reen");
        exp_rx++;
        chk_cnts("reen");
        chk("fifo_empty_pops", viol_empty, 0);

        // Reset on beat 2 of 5.
        push_pkt(1'b0, 5, 11'd40, 8'h71);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            found = m_tvalid && (m_tdata == mkdata(1'b0, 8'h71, 1));
        end
        chk("rst_mid_found", found, 1'b1);
        pcie_rst = 1'b1;
        #1;
        chk("rst_mid_tvalid", m_tvalid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        rx_q.delete();
        tx_q.delete();
        out_q.delete();
        drive_heads();
        repeat (2) @(posedge pcie_clk);
        #1;
        pcie_rst = 1'b0;
        exp_rx = 0;
        exp_tx = 0;
        exp_tr = 0;
        repeat (3) tick();
        chk("rst_rel_busy", busy, 1'b0);
        chk("rst_rel_tvalid", m_tvalid, 1'b0);
        chk_cnts("rst_rel");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
